// File: rtl/nn_pkg.sv
// Shared definitions for the fully-connected layer sequencer: default widths
// and the controller state encoding.
package nn_pkg;

    localparam int NN_AW = 10;
    localparam int NN_CW = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ISSUE = 3'd2,
        S_DRAIN = 3'd3,
        S_WRITE = 3'd4,
        S_DONE  = 3'd5
    } nn_state_e;

endpackage

// File: rtl/nn_loop_cnt.sv
// Loop index counter: synchronous load-to-zero, count enable, and a flag that
// is high while the count equals the supplied last index.
module nn_loop_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic         i_en,
    input  logic [W-1:0] i_last,
    output logic [W-1:0] o_cnt,
    output logic         o_tc
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;
    assign o_tc  = (r_cnt == i_last);

endmodule

// File: rtl/nn_layer_seq.sv
// Sequencer for one fully-connected layer: streams N weight/activation reads
// per output neuron into the MAC, then writes each of the M results back.
module nn_layer_seq
    import nn_pkg::*;
#(
    parameter int AW = NN_AW,
    parameter int CW = NN_CW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [CW-1:0] cfg_n_in,
    input  logic [CW-1:0] cfg_n_out,
    input  logic [AW-1:0] cfg_w_base,
    input  logic [AW-1:0] cfg_x_base,
    input  logic          cfg_relu,
    output logic          mem_req,
    input  logic          mem_gnt,
    output logic [AW-1:0] w_addr,
    output logic [AW-1:0] x_addr,
    output logic          alu_clr,
    output logic          alu_acc_en,
    output logic          reg_wr_en,
    output logic [CW-1:0] reg_waddr,
    output logic          relu_en,
    output logic          busy,
    output logic          done,
    output nn_state_e     dbg_state
);

    nn_state_e     r_state;
    nn_state_e     w_next;
    logic [CW-1:0] r_n_in;
    logic [CW-1:0] r_n_out;
    logic [AW-1:0] r_x_base;
    logic [AW-1:0] r_w_ptr;
    logic          r_relu;
    logic          r_acc_en;

    logic          w_latch;
    logic          w_grant;
    logic          w_i_load;
    logic          w_i_en;
    logic          w_o_load;
    logic          w_o_en;
    logic [CW-1:0] w_i_cnt;
    logic [CW-1:0] w_o_cnt;
    logic          w_i_tc;
    logic          w_o_tc;
    logic          w_empty_cfg;

    assign w_empty_cfg = (cfg_n_in == '0) || (cfg_n_out == '0);

    nn_loop_cnt #(.W(CW)) u_i_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_i_load),
        .i_en   (w_i_en),
        .i_last (r_n_in - CW'(1)),
        .o_cnt  (w_i_cnt),
        .o_tc   (w_i_tc)
    );

    nn_loop_cnt #(.W(CW)) u_o_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_o_load),
        .i_en   (w_o_en),
        .i_last (r_n_out - CW'(1)),
        .o_cnt  (w_o_cnt),
        .o_tc   (w_o_tc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_n_in   <= '0;
            r_n_out  <= '0;
            r_x_base <= '0;
            r_w_ptr  <= '0;
            r_relu   <= 1'b0;
            r_acc_en <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_acc_en <= w_grant;
            if (w_latch) begin
                r_n_in   <= cfg_n_in;
                r_n_out  <= cfg_n_out;
                r_x_base <= cfg_x_base;
                r_w_ptr  <= cfg_w_base;
                r_relu   <= cfg_relu;
            end else if (w_grant) begin
                // Weight pointer runs on across neurons, giving w_base + o*N + i.
                r_w_ptr <= r_w_ptr + AW'(1);
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_grant  = 1'b0;
        w_i_load = 1'b0;
        w_i_en   = 1'b0;
        w_o_load = 1'b0;
        w_o_en   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_latch  = 1'b1;
                    w_o_load = 1'b1;
                    w_next   = w_empty_cfg ? S_DONE : S_CLEAR;
                end
            end
            S_CLEAR: begin
                w_i_load = 1'b1;
                w_next   = S_ISSUE;
            end
            S_ISSUE: begin
                if (mem_gnt) begin
                    w_grant = 1'b1;
                    w_i_en  = 1'b1;
                    if (w_i_tc) w_next = S_DRAIN;
                end
            end
            S_DRAIN: w_next = S_WRITE;
            S_WRITE: begin
                if (w_o_tc) begin
                    w_next = S_DONE;
                end else begin
                    w_o_en = 1'b1;
                    w_next = S_CLEAR;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign mem_req    = (r_state == S_ISSUE);
    assign w_addr     = r_w_ptr;
    assign x_addr     = r_x_base + AW'(w_i_cnt);
    assign alu_clr    = (r_state == S_CLEAR);
    assign alu_acc_en = r_acc_en;
    assign reg_wr_en  = (r_state == S_WRITE);
    assign reg_waddr  = w_o_cnt;
    assign relu_en    = r_relu;
    assign busy       = (r_state != S_IDLE);
    assign done       = (r_state == S_DONE);
    assign dbg_state  = r_state;

endmodule
